// File: rtl/ram_stream_reader.sv
// ram_stream_reader: turns an (address, length) command into a valid/ready
// word stream read from a synchronous RAM with a 1- or 2-cycle read latency.
// Reads are issued only while the output FIFO has room for every read that is
// already in flight, so the FIFO can never overflow even when the sink stalls.
module ram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1   // 1 = non-registered RAM, 2 = output-registered RAM
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_len,
  output logic                  ram_enable,
  output logic                  ram_write,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_odata,
  output logic                  ovalid,
  input  logic                  oready,
  output logic [DATA_WIDTH-1:0] odata,
  output logic                  olast
);

  localparam int DEPTH = LATENCY + 2;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LATENCY-1:0]    tag_q, tag_d;
  logic [LATENCY-1:0]    ltag_q, ltag_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [DEPTH];
  logic                  fifo_last_q [DEPTH];
  logic [CW:0]           occupancy;
  logic                  issue;
  logic                  push;
  logic                  pop;

  assign ram_write = 1'b0;

  // Next-state, read issue, FIFO bookkeeping and stream outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tag_d      = tag_q;
    ltag_d     = ltag_q;
    cmd_ready  = (state_q == S_IDLE);
    ram_enable = (state_q != S_IDLE);
    // Reserve a FIFO slot for every read still travelling through the RAM.
    occupancy  = {1'b0, inflight_q} + {1'b0, count_q};
    issue      = (state_q == S_READ) && (occupancy < (CW+1)'(DEPTH));
    push       = tag_q[LATENCY-1];
    pop        = (count_q != '0) && oready;
    // The issued address goes out in the issue cycle and is held afterwards.
    ram_addr   = issue ? addr_q : ram_addr_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d  = cmd_addr;
          rem_d   = cmd_len;
          state_d = S_READ;
        end
      end
      S_READ: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (rem_q == '0) begin
            state_d = S_DRAIN;
          end else begin
            rem_d = rem_q - 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (inflight_q == '0 && count_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Issue tags follow the RAM pipeline, which only moves while enabled.
    if (ram_enable) begin
      tag_d[0]  = issue;
      ltag_d[0] = issue && (rem_q == '0);
      for (int i = 1; i < LATENCY; i++) begin
        tag_d[i]  = tag_q[i-1];
        ltag_d[i] = ltag_q[i-1];
      end
    end

    inflight_d = inflight_q + CW'(issue) - CW'(push);
    count_d    = count_q + CW'(push) - CW'(pop);
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end

    // Head of the FIFO; forced to zero when empty so nothing stale shows.
    ovalid = (count_q != '0);
    odata  = ovalid ? fifo_data_q[rd_ptr_q] : '0;
    olast  = ovalid ? fifo_last_q[rd_ptr_q] : 1'b0;
  end

  // Control state, counters and issue tags with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      ram_addr_q <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      tag_q      <= '0;
      ltag_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      ram_addr_q <= ram_addr;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      tag_q      <= tag_d;
      ltag_q     <= ltag_d;
    end
  end

  // FIFO storage; contents need no reset because occupancy gates the output.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= ram_odata;
      fifo_last_q[wr_ptr_q] <= ltag_q[LATENCY-1];
    end
  end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: one instance per legal RAM latency (1 and 2)
// runs the same command stream against a behavioural RAM; each delivered word
// is compared with mem[(addr+k) mod 1024] and the last flag with k==len.
module tb_ram_stream_reader;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_addr = '0;
  logic [9:0] cmd_len = '0;
  logic       oready = 1'b0;

  logic       cmd_ready_s  [2];
  logic       ram_enable_s [2];
  logic       ram_write_s  [2];
  logic [9:0] ram_addr_s   [2];
  logic [7:0] ram_odata_s  [2];
  logic       ovalid_s     [2];
  logic [7:0] odata_s      [2];
  logic       olast_s      [2];

  logic [7:0] mem [1024];
  logic [7:0] r0, r1a, r1b;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Monitor state (written only by the monitor process)
  int         rx_n      [2] = '{0, 0};
  logic [7:0] rx_d      [2][1100];
  logic       rx_l      [2][1100];
  int         rx_c      [2][1100];
  int         an        [2] = '{0, 0};
  logic [9:0] alog      [2][16];
  logic [9:0] last_addr [2];
  int         acc_cyc   [2] = '{0, 0};
  int         first_cyc [2] = '{0, 0};
  bit         got_first [2] = '{0, 0};
  bit         was_stall [2] = '{0, 0};
  logic [7:0] st_d      [2];
  logic       st_l      [2];
  int         stall_err [2] = '{0, 0};
  int         occ_err   [2] = '{0, 0};

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    ram_stream_reader #(
      .DATA_WIDTH(8),
      .ADDR_WIDTH(10),
      .LATENCY   (gi + 1)
    ) u_dut (
      .clock     (clock),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready_s[gi]),
      .cmd_addr  (cmd_addr),
      .cmd_len   (cmd_len),
      .ram_enable(ram_enable_s[gi]),
      .ram_write (ram_write_s[gi]),
      .ram_addr  (ram_addr_s[gi]),
      .ram_odata (ram_odata_s[gi]),
      .ovalid    (ovalid_s[gi]),
      .oready    (oready),
      .odata     (odata_s[gi]),
      .olast     (olast_s[gi])
    );
  end

  // Behavioural RAMs: one-stage read for instance 0, two-stage for instance 1
  always @(posedge clock) begin
    if (ram_enable_s[0]) r0 <= mem[ram_addr_s[0]];
    if (ram_enable_s[1]) begin
      r1a <= mem[ram_addr_s[1]];
      r1b <= r1a;
    end
  end
  assign ram_odata_s[0] = r0;
  assign ram_odata_s[1] = r1b;

  // Monitor: handshakes, issued addresses, stall stability, outstanding reads
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (reset) begin
        was_stall[d] = 1'b0;
        an[d] = 0;
        rx_n[d] = 0;
      end else begin
        if (was_stall[d] && !(ovalid_s[d] && odata_s[d] == st_d[d] && olast_s[d] == st_l[d]))
          stall_err[d]++;
        was_stall[d] = ovalid_s[d] && !oready;
        st_d[d] = odata_s[d];
        st_l[d] = olast_s[d];
        if (cmd_valid && cmd_ready_s[d]) begin
          acc_cyc[d] = cyc;
          rx_n[d] = 0;
          an[d] = 0;
          got_first[d] = 1'b0;
        end else begin
          if (ram_enable_s[d] && (an[d] == 0 || ram_addr_s[d] != last_addr[d])) begin
            if (an[d] < 16) alog[d][an[d]] = ram_addr_s[d];
            an[d]++;
            last_addr[d] = ram_addr_s[d];
          end
          if (an[d] - rx_n[d] > d + 3) occ_err[d]++;
          if (ovalid_s[d] && !got_first[d]) begin
            first_cyc[d] = cyc;
            got_first[d] = 1'b1;
          end
          if (ovalid_s[d] && oready) begin
            if (rx_n[d] < 1100) begin
              rx_d[d][rx_n[d]] = odata_s[d];
              rx_l[d][rx_n[d]] = olast_s[d];
              rx_c[d][rx_n[d]] = cyc;
            end
            rx_n[d]++;
          end
        end
      end
    end
  end

  // Drive one command; mode 0: oready=1, 1: random oready, 2: oready=0 for 20 cycles
  task automatic run_cmd(input logic [9:0] a, input logic [9:0] l, input int mode);
    int k;
    bit done;
    @(posedge clock); #1;
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = l;
    oready    = (mode == 1) ? 1'($urandom_range(0, 1)) : (mode == 0);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!(cmd_ready_s[0] && cmd_ready_s[1]) && k < 50);
    checks++;
    if (!(cmd_ready_s[0] && cmd_ready_s[1])) begin
      errors++;
      $display("FAIL cmd_accept ready got %0b%0b required 11", cmd_ready_s[0], cmd_ready_s[1]);
    end
    k = 0;
    done = 1'b0;
    while (!done && k < 3000) begin
      @(posedge clock); #1;
      cmd_valid = 1'b0;
      if (mode == 1) oready = 1'($urandom_range(0, 1));
      else if (mode == 2) oready = (k >= 20);
      else oready = 1'b1;
      @(negedge clock);
      k++;
      done = cmd_ready_s[0] && cmd_ready_s[1];
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL cmd_done timeout after %0d cycles, required return to idle", k);
    end
    $display("cmd addr=%0d len=%0d mode=%0d words=%0d/%0d cycles=%0d", a, l, mode, rx_n[0], rx_n[1], k);
  endtask

  task automatic test_reset;
    logic [22:0] got;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      got = {cmd_ready_s[d], ram_enable_s[d], ram_write_s[d], ram_addr_s[d],
             ovalid_s[d], olast_s[d], odata_s[d]};
      checks++;
      if (got !== 23'h40_0000) begin
        errors++;
        $display("FAIL reset_state dut%0d got %h required 400000", d, got);
      end
    end
  endtask

  task automatic test_basic;
    logic [9:0] ea;
    run_cmd(10'd5, 10'd3, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rx_n[d] !== 4) begin
        errors++;
        $display("FAIL basic_count dut%0d got %0d required 4", d, rx_n[d]);
      end
      checks++;
      if (first_cyc[d] - acc_cyc[d] !== d + 3) begin
        errors++;
        $display("FAIL basic_latency dut%0d got %0d required %0d", d, first_cyc[d] - acc_cyc[d], d + 3);
      end
      for (int k = 0; k < 4; k++) begin
        ea = 10'(5 + k);
        checks++;
        if ({rx_d[d][k], rx_l[d][k]} !== {mem[ea], k == 3} || rx_c[d][k] !== first_cyc[d] + k) begin
          errors++;
          $display("FAIL basic_word dut%0d k=%0d got %h/%b@%0d required %h/%b@%0d", d, k,
                   rx_d[d][k], rx_l[d][k], rx_c[d][k], mem[ea], k == 3, first_cyc[d] + k);
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [9:0] ea;
    run_cmd(10'd1022, 10'd3, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (an[d] !== 4 || rx_n[d] !== 4) begin
        errors++;
        $display("FAIL wrap_count dut%0d got issues=%0d words=%0d required 4/4", d, an[d], rx_n[d]);
      end
      for (int k = 0; k < 4; k++) begin
        ea = 10'(1022 + k);
        checks++;
        if (alog[d][k] !== ea || rx_d[d][k] !== mem[ea] || rx_l[d][k] !== (k == 3)) begin
          errors++;
          $display("FAIL wrap_seq dut%0d k=%0d got addr %0d data %h last %b required %0d %h %b",
                   d, k, alog[d][k], rx_d[d][k], rx_l[d][k], ea, mem[ea], k == 3);
        end
      end
    end
  endtask

  task automatic test_stall;
    logic [9:0] ea;
    int k;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_addr = 10'd100; cmd_len = 10'd9; oready = 1'b0;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (20) @(negedge clock);
    for (int d = 0; d < 2; d++) begin
      ea = 10'(100 + d + 2);
      checks++;
      if (ram_addr_s[d] !== ea || ovalid_s[d] !== 1'b1 || odata_s[d] !== mem[100] || rx_n[d] !== 0) begin
        errors++;
        $display("FAIL stall_hold dut%0d got addr %0d valid %b data %h words %0d required %0d 1 %h 0",
                 d, ram_addr_s[d], ovalid_s[d], odata_s[d], rx_n[d], ea, mem[100]);
      end
    end
    @(posedge clock); #1 oready = 1'b1;
    k = 0;
    while (!(cmd_ready_s[0] && cmd_ready_s[1]) && k < 200) begin
      @(negedge clock);
      k++;
    end
    $display("stall release words=%0d/%0d cycles=%0d", rx_n[0], rx_n[1], k);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rx_n[d] !== 10) begin
        errors++;
        $display("FAIL stall_count dut%0d got %0d required 10", d, rx_n[d]);
      end
      for (int j = 0; j < 10; j++) begin
        ea = 10'(100 + j);
        checks++;
        if ({rx_d[d][j], rx_l[d][j]} !== {mem[ea], j == 9}) begin
          errors++;
          $display("FAIL stall_word dut%0d k=%0d got %h/%b required %h/%b", d, j,
                   rx_d[d][j], rx_l[d][j], mem[ea], j == 9);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [9:0] a, ea;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    a = 10'($urandom);
    run_cmd(a, 10'd15, 1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rx_n[d] !== 16) begin
        errors++;
        $display("FAIL random_count dut%0d got %0d required 16", d, rx_n[d]);
      end
      for (int k = 0; k < 16; k++) begin
        ea = a + 10'(k);
        checks++;
        if ({rx_d[d][k], rx_l[d][k]} !== {mem[ea], k == 15}) begin
          errors++;
          $display("FAIL random_word dut%0d k=%0d got %h/%b required %h/%b", d, k,
                   rx_d[d][k], rx_l[d][k], mem[ea], k == 15);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    @(posedge clock); #1;
    cmd_valid = 1'b1; cmd_addr = 10'd200; cmd_len = 10'd9; oready = 1'b1;
    @(posedge clock); #1;
    cmd_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (ovalid_s[d] !== 1'b0 || cmd_ready_s[d] !== 1'b1) begin
          errors++;
          $display("FAIL reset_mid_idle dut%0d c=%0d got ovalid %b ready %b required 0 1",
                   d, c, ovalid_s[d], cmd_ready_s[d]);
        end
      end
    end
    run_cmd(10'd0, 10'd0, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rx_n[d] !== 1 || rx_d[d][0] !== mem[0] || rx_l[d][0] !== 1'b1) begin
        errors++;
        $display("FAIL reset_mid_single dut%0d got n=%0d %h/%b required 1 %h/1", d, rx_n[d],
                 rx_d[d][0], rx_l[d][0], mem[0]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [9:0] a, l, ea;
    for (int t = 0; t < 4; t++) begin
      a = 10'($urandom);
      l = 10'($urandom_range(0, 20));
      run_cmd(a, l, int'($urandom_range(0, 1)));
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (rx_n[d] !== int'(l) + 1) begin
          errors++;
          $display("FAIL b2b_count dut%0d t=%0d got %0d required %0d", d, t, rx_n[d], int'(l) + 1);
        end
        for (int k = 0; k <= int'(l); k++) begin
          ea = a + 10'(k);
          checks++;
          if ({rx_d[d][k], rx_l[d][k]} !== {mem[ea], k == int'(l)}) begin
            errors++;
            $display("FAIL b2b_word dut%0d t=%0d k=%0d got %h/%b required %h/%b", d, t, k,
                     rx_d[d][k], rx_l[d][k], mem[ea], k == int'(l));
          end
        end
      end
    end
  endtask

  task automatic test_full;
    logic [9:0] ea;
    run_cmd(10'd3, 10'h3FF, 0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rx_n[d] !== 1024) begin
        errors++;
        $display("FAIL full_count dut%0d got %0d required 1024", d, rx_n[d]);
      end
      for (int k = 0; k < 1024; k++) begin
        ea = 10'(3 + k);
        checks++;
        if ({rx_d[d][k], rx_l[d][k]} !== {mem[ea], k == 1023}) begin
          errors++;
          $display("FAIL full_word dut%0d k=%0d got %h/%b required %h/%b", d, k,
                   rx_d[d][k], rx_l[d][k], mem[ea], k == 1023);
        end
      end
    end
  endtask

  task automatic test_protocol;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (stall_err[d] !== 0 || occ_err[d] !== 0) begin
        errors++;
        $display("FAIL protocol dut%0d got stall_err %0d occ_err %0d required 0 0",
                 d, stall_err[d], occ_err[d]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
    test_reset;
    test_basic;
    test_wrap;
    test_stall;
    test_random;
    test_reset_mid;
    test_back_to_back;
    test_full;
    test_protocol;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
